// File: rtl/pagerank_pkg.sv
// Shared pagerank types and widths, used by the stream transmitter and by pagerank_comp.
package pagerank_pkg;

  localparam int unsigned PR_WIDTH   = 64;
  localparam int unsigned ITER_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    DONE,
    WAIT_NEXT,
    HALT
  } tx_state_t;

endpackage

// File: rtl/pagerank_stream_tx_if.sv
// Valid/ready beat stream from the pagerank transmitter to pagerank_comp, with pass framing.
interface pagerank_stream_tx_if #(
  parameter int unsigned IDX_W = 2
);
  import pagerank_pkg::*;

  logic [PR_WIDTH-1:0] stream_data;
  logic [IDX_W-1:0]    stream_index;
  logic                stream_valid;
  logic                stream_ready;
  logic                stream_start;
  logic                stream_done;

  modport master (
    output stream_data,
    output stream_index,
    output stream_valid,
    output stream_start,
    output stream_done,
    input  stream_ready
  );

  modport slave (
    input  stream_data,
    input  stream_index,
    input  stream_valid,
    input  stream_start,
    input  stream_done,
    output stream_ready
  );

endinterface

// File: rtl/pagerank_stream_tx.sv
// Snapshots the accumulated pagerank vector and streams it one word per accepted beat,
// pacing passes on the consumer's nextIteration / pagerank_complete feedback.
module pagerank_stream_tx
  import pagerank_pkg::*;
#(
  parameter int unsigned NODES_IN_GRAPH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PR_WIDTH-1:0]   pagerank_accum [NODES_IN_GRAPH],
  input  logic                  accum_valid,
  output logic                  accum_ready,
  pagerank_stream_tx_if.master  stream,
  input  logic                  nextIteration,
  input  logic                  pagerank_complete,
  output logic [ITER_WIDTH-1:0] tx_iteration,
  output logic                  tx_halted
);

  localparam int unsigned IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES_IN_GRAPH - 1);

  tx_state_t           state;
  logic [PR_WIDTH-1:0] snap_buf [NODES_IN_GRAPH];
  logic [IDX_W-1:0]    idx_next;

  assign idx_next = stream.stream_index + IDX_W'(1);

  // All outputs are registered here so no input reaches an output combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      accum_ready         <= 1'b1;
      stream.stream_valid <= 1'b0;
      stream.stream_start <= 1'b0;
      stream.stream_done  <= 1'b0;
      stream.stream_data  <= '0;
      stream.stream_index <= '0;
      tx_iteration        <= '0;
      tx_halted           <= 1'b0;
      for (int i = 0; i < int'(NODES_IN_GRAPH); i++) snap_buf[i] <= '0;
    end else begin
      stream.stream_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accum_valid) begin
            snap_buf            <= pagerank_accum;
            state               <= SEND;
            accum_ready         <= 1'b0;
            stream.stream_valid <= 1'b1;
            stream.stream_start <= 1'b1;
            stream.stream_data  <= pagerank_accum[0];
            stream.stream_index <= '0;
          end
        end
        SEND: begin
          if (stream.stream_ready) begin
            if (stream.stream_index == LAST_IDX) begin
              state               <= DONE;
              stream.stream_valid <= 1'b0;
              stream.stream_start <= 1'b0;
              stream.stream_done  <= 1'b1;
              tx_iteration        <= tx_iteration + ITER_WIDTH'(1);
            end else begin
              stream.stream_index <= idx_next;
              stream.stream_data  <= snap_buf[idx_next];
              stream.stream_start <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= WAIT_NEXT;
        end
        WAIT_NEXT: begin
          // Convergence takes priority over a simultaneous request for another pass.
          if (pagerank_complete) begin
            state     <= HALT;
            tx_halted <= 1'b1;
          end else if (nextIteration) begin
            state       <= IDLE;
            accum_ready <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_stream_tx.sv
// Randomized self-checking bench for pagerank_stream_tx; expected beats come from the snapshot.
module tb_pagerank_stream_tx;
  import pagerank_pkg::*;

  localparam int N = 4;
  typedef logic [63:0] word_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  word_t       accum [N];
  logic        accum_valid = 1'b0, accum_ready;
  logic        next_it = 1'b0, complete = 1'b0;
  logic [31:0] tx_iter;
  logic        halted;

  word_t       accum1 [1];
  logic        accum_valid1 = 1'b0, accum_ready1;
  logic [31:0] tx_iter1;
  logic        halted1;

  pagerank_stream_tx_if #(.IDX_W(2)) s4 ();
  pagerank_stream_tx_if #(.IDX_W(1)) s1 ();

  pagerank_stream_tx #(.NODES_IN_GRAPH(N)) dut (
    .clock(clock), .reset_n(reset_n), .pagerank_accum(accum), .accum_valid(accum_valid),
    .accum_ready(accum_ready), .stream(s4), .nextIteration(next_it),
    .pagerank_complete(complete), .tx_iteration(tx_iter), .tx_halted(halted)
  );

  pagerank_stream_tx #(.NODES_IN_GRAPH(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .pagerank_accum(accum1), .accum_valid(accum_valid1),
    .accum_ready(accum_ready1), .stream(s1), .nextIteration(1'b0),
    .pagerank_complete(1'b0), .tx_iteration(tx_iter1), .tx_halted(halted1)
  );

  int    tests = 0, fails = 0;
  int    exp_iter = 0;
  word_t got_d[$];
  int    got_i[$];
  int    start_errs, hold_errs, stall_cnt, cyc;
  bit    saw_done;

  // Offers a snapshot then plays the consumer, recording every accepted beat.
  // ready_mode: 0 = always ready, 1 = stall stall_len cycles at index stall_at, 2 = random.
  task automatic collect(input word_t snap[N], input int ready_mode, input int stall_at,
                         input int stall_len);
    bit    prev_hold = 0;
    word_t pd = '0;
    int    pi = 0;
    logic  ps = 1'b0;
    got_d.delete(); got_i.delete();
    start_errs = 0; hold_errs = 0; stall_cnt = 0; cyc = 0; saw_done = 0;
    @(negedge clock);
    accum = snap; accum_valid = 1'b1; s4.stream_ready = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      // Inputs that must be ignored outside IDLE / WAIT_NEXT get random noise.
      accum_valid = 1'($urandom_range(0, 1));
      next_it = 1'($urandom_range(0, 1));
      complete = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) accum[k] = {$urandom, $urandom};
      if (s4.stream_done) begin
        saw_done = 1; cyc = i;
        if (s4.stream_valid) hold_errs++;
        break;
      end
      if (prev_hold && (!s4.stream_valid || s4.stream_data !== pd ||
                        int'(s4.stream_index) != pi || s4.stream_start !== ps))
        hold_errs++;
      case (ready_mode)
        0: s4.stream_ready = 1'b1;
        1: s4.stream_ready = !(s4.stream_valid && int'(s4.stream_index) == stall_at &&
                               stall_cnt < stall_len);
        default: s4.stream_ready = 1'($urandom_range(0, 1));
      endcase
      if (s4.stream_valid && s4.stream_ready) begin
        got_d.push_back(s4.stream_data);
        got_i.push_back(int'(s4.stream_index));
        if (s4.stream_start !== (s4.stream_index == 2'd0)) start_errs++;
      end
      if (s4.stream_valid && !s4.stream_ready) stall_cnt++;
      prev_hold = s4.stream_valid && !s4.stream_ready;
      pd = s4.stream_data; pi = int'(s4.stream_index); ps = s4.stream_start;
    end
    accum_valid = 1'b0; next_it = 1'b0; complete = 1'b0; s4.stream_ready = 1'b1;
  endtask

  task automatic go_next();
    next_it = 1'b1;
    @(negedge clock);
    next_it = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s4.stream_ready = 1'b1; s1.stream_ready = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (accum_ready !== 1'b1 || s4.stream_valid !== 1'b0 || s4.stream_start !== 1'b0 ||
        s4.stream_done !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got rdy=%b v=%b s=%b d=%b h=%b exp 1 0 0 0 0", accum_ready,
               s4.stream_valid, s4.stream_start, s4.stream_done, halted);
    end
    tests++;
    if (s4.stream_data !== 64'd0 || s4.stream_index !== 2'd0 || tx_iter !== 32'd0) begin
      fails++;
      $display("FAIL reset_data got data=%0h idx=%0d iter=%0d exp 0 0 0", s4.stream_data,
               s4.stream_index, tx_iter);
    end
    reset_n = 1'b1;
    @(negedge clock);
    tests++;
    if (accum_ready !== 1'b1 || accum_ready1 !== 1'b1 || tx_iter1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_release got rdy=%b rdy1=%b iter1=%0d exp 1 1 0", accum_ready,
               accum_ready1, tx_iter1);
    end
  endtask

  task automatic test_basic_pass();
    word_t snap[N];
    for (int k = 0; k < N; k++) snap[k] = word_t'(k + 1);
    collect(snap, 0, 0, 0);
    exp_iter++;
    tests++;
    if (!saw_done || got_d.size() != N) begin
      fails++;
      $display("FAIL basic_beats got done=%0d beats=%0d exp 1 %0d", saw_done, got_d.size(), N);
    end
    for (int k = 0; k < N && k < got_d.size(); k++) begin
      tests++;
      if (got_d[k] !== snap[k] || got_i[k] != k) begin
        fails++;
        $display("FAIL basic_beat%0d got data=%0h idx=%0d exp data=%0h idx=%0d", k, got_d[k],
                 got_i[k], snap[k], k);
      end
    end
    tests++;
    if (start_errs != 0 || hold_errs != 0 || cyc != N + 1) begin
      fails++;
      $display("FAIL basic_timing got start_errs=%0d hold_errs=%0d done_cycle=%0d exp 0 0 %0d",
               start_errs, hold_errs, cyc, N + 1);
    end
    tests++;
    if (tx_iter !== 32'(exp_iter) || s4.stream_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_iter got iter=%0d valid=%b exp %0d 0", tx_iter, s4.stream_valid,
               exp_iter);
    end
    @(negedge clock);
    tests++;
    if (s4.stream_done !== 1'b0 || accum_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse got done=%b rdy=%b exp 0 0", s4.stream_done, accum_ready);
    end
  endtask

  task automatic test_backpressure();
    word_t snap[N];
    go_next();
    tests++;
    if (accum_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready got %b exp 1", accum_ready);
    end
    for (int k = 0; k < N; k++) snap[k] = word_t'(k + 1);
    collect(snap, 1, 2, 3);
    exp_iter++;
    tests++;
    if (!saw_done || got_d.size() != N || stall_cnt != 3 || hold_errs != 0 || cyc != N + 4) begin
      fails++;
      $display("FAIL bp_stream got done=%0d beats=%0d stalls=%0d hold_errs=%0d cycle=%0d exp 1 %0d 3 0 %0d",
               saw_done, got_d.size(), stall_cnt, hold_errs, cyc, N, N + 4);
    end
    for (int k = 0; k < N && k < got_d.size(); k++) begin
      tests++;
      if (got_d[k] !== snap[k] || got_i[k] != k) begin
        fails++;
        $display("FAIL bp_beat%0d got data=%0h idx=%0d exp data=%0h idx=%0d", k, got_d[k],
                 got_i[k], snap[k], k);
      end
    end
    tests++;
    if (tx_iter !== 32'(exp_iter)) begin
      fails++;
      $display("FAIL bp_iter got %0d exp %0d", tx_iter, exp_iter);
    end
    @(negedge clock);
  endtask

  task automatic test_random_passes(input int passes, input bit fixed_first);
    word_t snap[N];
    for (int p = 0; p < passes; p++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        accum_valid = 1'b1;
        @(negedge clock);
        accum_valid = 1'b0;
        tests++;
        if (s4.stream_valid !== 1'b0 || accum_ready !== 1'b0) begin
          fails++;
          $display("FAIL wait_ignore got valid=%b rdy=%b exp 0 0", s4.stream_valid, accum_ready);
        end
      end
      go_next();
      for (int k = 0; k < N; k++)
        snap[k] = (fixed_first && p == 0) ? word_t'(k + 5) : {$urandom, $urandom};
      collect(snap, 2, 0, 0);
      exp_iter++;
      tests++;
      if (!saw_done || got_d.size() != N || start_errs != 0 || hold_errs != 0 ||
          cyc != N + 1 + stall_cnt) begin
        fails++;
        $display("FAIL rand_pass%0d got done=%0d beats=%0d start_errs=%0d hold_errs=%0d cycle=%0d exp 1 %0d 0 0 %0d",
                 p, saw_done, got_d.size(), start_errs, hold_errs, cyc, N, N + 1 + stall_cnt);
      end
      for (int k = 0; k < N && k < got_d.size(); k++) begin
        tests++;
        if (got_d[k] !== snap[k] || got_i[k] != k) begin
          fails++;
          $display("FAIL rand_pass%0d_beat%0d got data=%0h idx=%0d exp data=%0h idx=%0d", p, k,
                   got_d[k], got_i[k], snap[k], k);
        end
      end
      tests++;
      if (tx_iter !== 32'(exp_iter)) begin
        fails++;
        $display("FAIL rand_pass%0d_iter got %0d exp %0d", p, tx_iter, exp_iter);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_halt();
    next_it = 1'b1; complete = 1'b1;
    @(negedge clock);
    next_it = 1'b0; complete = 1'b0;
    tests++;
    if (halted !== 1'b1 || accum_ready !== 1'b0) begin
      fails++;
      $display("FAIL halt_enter got halted=%b rdy=%b exp 1 0", halted, accum_ready);
    end
    accum_valid = 1'b1; next_it = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests++;
      if (s4.stream_valid !== 1'b0 || accum_ready !== 1'b0 || halted !== 1'b1 ||
          tx_iter !== 32'(exp_iter)) begin
        fails++;
        $display("FAIL halt_stay%0d got valid=%b rdy=%b halted=%b iter=%0d exp 0 0 1 %0d", i,
                 s4.stream_valid, accum_ready, halted, tx_iter, exp_iter);
      end
    end
    accum_valid = 1'b0; next_it = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    word_t snap[N];
    bit    hit = 0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_iter = 0;
    @(negedge clock);
    for (int k = 0; k < N; k++) snap[k] = {$urandom, $urandom};
    accum = snap; accum_valid = 1'b1; s4.stream_ready = 1'b1;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clock);
      accum_valid = 1'b0;
      if (s4.stream_valid && s4.stream_index == 2'd1) hit = 1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_reach_idx1 got 0 exp 1");
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (s4.stream_valid !== 1'b0 || s4.stream_start !== 1'b0 || s4.stream_done !== 1'b0 ||
        s4.stream_data !== 64'd0 || s4.stream_index !== 2'd0 || accum_ready !== 1'b1 ||
        tx_iter !== 32'd0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_reset got v=%b s=%b d=%b data=%0h idx=%0d rdy=%b iter=%0d h=%b exp all reset",
               s4.stream_valid, s4.stream_start, s4.stream_done, s4.stream_data,
               s4.stream_index, accum_ready, tx_iter, halted);
    end
    @(negedge clock);
    tests++;
    if (s4.stream_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_done got %b exp 0", s4.stream_done);
    end
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) snap[k] = 64'd9;
    collect(snap, 0, 0, 0);
    exp_iter++;
    tests++;
    if (!saw_done || got_d.size() != N || start_errs != 0 || cyc != N + 1 ||
        tx_iter !== 32'(exp_iter)) begin
      fails++;
      $display("FAIL mid_restart got done=%0d beats=%0d start_errs=%0d cycle=%0d iter=%0d exp 1 %0d 0 %0d %0d",
               saw_done, got_d.size(), start_errs, cyc, tx_iter, N, N + 1, exp_iter);
    end
    for (int k = 0; k < N && k < got_d.size(); k++) begin
      tests++;
      if (got_d[k] !== 64'd9 || got_i[k] != k) begin
        fails++;
        $display("FAIL mid_beat%0d got data=%0h idx=%0d exp data=9 idx=%0d", k, got_d[k],
                 got_i[k], k);
      end
    end
  endtask

  task automatic test_single_node();
    @(negedge clock);
    accum1[0] = 64'd42; accum_valid1 = 1'b1; s1.stream_ready = 1'b1;
    @(negedge clock);
    accum_valid1 = 1'b0; accum1[0] = 64'hdead;
    tests++;
    if (s1.stream_valid !== 1'b1 || s1.stream_data !== 64'd42 || s1.stream_index !== 1'b0 ||
        s1.stream_start !== 1'b1 || s1.stream_done !== 1'b0) begin
      fails++;
      $display("FAIL single_beat got v=%b data=%0h idx=%0d s=%b d=%b exp 1 2a 0 1 0",
               s1.stream_valid, s1.stream_data, s1.stream_index, s1.stream_start,
               s1.stream_done);
    end
    @(negedge clock);
    tests++;
    if (s1.stream_done !== 1'b1 || s1.stream_valid !== 1'b0 || tx_iter1 !== 32'd1) begin
      fails++;
      $display("FAIL single_done got d=%b v=%b iter=%0d exp 1 0 1", s1.stream_done,
               s1.stream_valid, tx_iter1);
    end
    @(negedge clock);
    tests++;
    if (s1.stream_done !== 1'b0 || accum_ready1 !== 1'b0) begin
      fails++;
      $display("FAIL single_wait got d=%b rdy=%b exp 0 0", s1.stream_done, accum_ready1);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) accum[k] = '0;
    accum1[0] = '0;
    test_reset();
    test_basic_pass();
    test_backpressure();
    test_random_passes(1, 1'b1);
    test_random_passes(5, 1'b0);
    test_halt();
    test_reset_mid_pass();
    test_single_node();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pagerank_stream_tx.md
# pagerank_stream_tx

Transmit side of the pagerank stream interface. Takes a per-iteration snapshot of the accumulated pagerank values from the scatter/gather stage and serializes it, one 64-bit word per accepted beat, into pagerank_comp. It frames each pass with stream_start/stream_done, honours consumer back-pressure, and paces iterations on pagerank_comp's nextIteration/pagerank_complete feedback.

## Interface
- NODES_IN_GRAPH, 4, number of pagerank values per pass; legal range is 1 or more.
- IDX_W, max(1,$clog2(NODES_IN_GRAPH)), derived localparam; not overridable.
- clock  input  1  single clock; all logic is posedge.
- reset_n  input  1  asynchronous, active-low reset.
- pagerank_accum[NODES_IN_GRAPH]  input  64 each  accumulated values for the current pass.
- accum_valid  input  1  snapshot request; honoured only while accum_ready=1.
- accum_ready  output  1  transmitter idle and able to accept a snapshot.
- stream_data  output  64  current word, registered.
- stream_index  output  IDX_W  node index of stream_data.
- stream_valid  output  1  stream_data/stream_index are valid.
- stream_ready  input  1  consumer accepts the beat when valid&ready.
- stream_start  output  1  high with stream_valid on index 0 only.
- stream_done  output  1  one-cycle pulse after the last beat is accepted.
- nextIteration  input  1  consumer requests another pass.
- pagerank_complete  input  1  consumer reports convergence.
- tx_iteration  output  32  count of completed passes.
- tx_halted  output  1  sticky; set once convergence is reported.

## Operation
- States, declared in the package enum: IDLE, SEND, DONE, WAIT_NEXT, HALT.
- IDLE
  - accum_ready=1.
  - On accum_valid: copy all pagerank_accum words into an internal buffer, set idx=0, go to SEND.
- SEND
  - stream_valid=1, stream_data=buf[idx], stream_index=idx, stream_start=(idx==0).
  - On valid&ready with idx<N-1: idx increments.
  - On valid&ready with idx==N-1: go to DONE.
  - With ready low, data, index and start hold stable.
- DONE
  - stream_done=1 and stream_valid=0 for exactly one cycle.
  - tx_iteration increments; 32-bit wrap is permitted.
  - Go to WAIT_NEXT.
- WAIT_NEXT
  - pagerank_complete → HALT.
  - Otherwise nextIteration → IDLE.
  - If both are high in the same cycle, complete wins.
- HALT
  - tx_halted=1; accum_ready=0; accum_valid is ignored.
  - Only reset exits this state.
- Inputs outside the listed states are ignored: accum_valid outside IDLE, nextIteration/pagerank_complete outside WAIT_NEXT.
- pagerank_accum is sampled only on the accepting cycle. Later input changes do not affect the pass in flight.
- NODES_IN_GRAPH=1: a single beat carries stream_start=1, then DONE follows.

## Timing
- Reset values: state IDLE; accum_ready=1; stream_valid, stream_start, stream_done, tx_halted=0; stream_data=0; stream_index=0; tx_iteration=0; buffer cleared.
- Asserting reset_n low mid-pass aborts immediately: outputs take their reset values asynchronously and no stream_done is emitted.
- Latency with accum_valid accepted at edge t:
  - stream_valid rises after edge t.
  - With stream_ready held high, beat k is accepted at edge t+1+k.
  - stream_done is high for the cycle after edge t+N; WAIT_NEXT follows at edge t+N+1.
- Throughput: one beat per cycle under continuous ready.
- Minimum gap between passes: two cycles (DONE plus WAIT_NEXT), then IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package pagerank_pkg holds:
  - PR_WIDTH=64
  - ITER_WIDTH=32
  - tx_state_t enum
- The same package is used by pagerank_comp.
- Single module. The snapshot buffer is an internal register array, not a separate sub-module.

## Test plan
- Reset, snapshot {1,2,3,4}, ready held high → beats 1,2,3,4 at indices 0..3 on consecutive cycles; start only with 1; done one cycle after 4; tx_iteration=1.
- Same pass with ready low for 3 cycles at index 2 → data=3 and index=2 held stable; no duplicate or skipped beat; done still after 4.
- In WAIT_NEXT, pulse nextIteration, then snapshot {5,6,7,8} → second pass streams 5..8; tx_iteration=2.
- nextIteration and pagerank_complete asserted together → HALT, tx_halted=1; a later accum_valid is ignored (accum_ready=0, no stream_valid).
- reset_n low during index 1 of a pass → all outputs return to reset values immediately; after release, a new snapshot {9,9,9,9} streams cleanly from index 0.
- NODES_IN_GRAPH=1, snapshot {42} → one beat with start=1 and index=0; done on the next cycle.
